// File: rtl/master_addr_tx_pkg.sv
// rtl/master_addr_tx_pkg.sv - shared bus definitions for the master address transmitter
// Purpose: state encodings of the master address FSM and the default slave
//          address width, shared by the master port and the address decoder so
//          both agree on the serialized address length.
// Ports:   none (package).
package master_addr_tx_pkg;

  localparam int DEFAULT_DEVICE_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ADDR      = 2'b01,
    ACK_WAIT  = 2'b10,
    CONNECTED = 2'b11
  } bus_state_e;

endpackage

// File: rtl/master_addr_tx_addr_piso.sv
// rtl/master_addr_tx_addr_piso.sv - parallel-load, right-shift address register
// Purpose: holds the slave address and presents it LSB-first on dout.
// Ports:
//   clk, rstn   - clock, asynchronous active-low reset
//   load        - capture din (takes priority over shift)
//   shift       - shift right by one, zero fill from the MSB side
//   din [W-1:0] - parallel address input
//   dout        - current LSB of the register
module addr_piso #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         dout
);

  logic [W-1:0] sh_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_q <= '0;
    end else if (load) begin
      sh_q <= din;
    end else if (shift) begin
      sh_q <= sh_q >> 1;
    end
  end

  assign dout = sh_q[0];

endmodule

// File: rtl/master_addr_tx.sv
// rtl/master_addr_tx.sv - master-side slave address serializer with ack timeout
// Purpose: on an accepted request, sends the slave address LSB-first on the
//          bus, waits for the decoder ack, then hands the bus to the core for
//          the data phase. A missing ack times out and pulses err.
// Ports:
//   clk, rstn                 - clock, asynchronous active-low reset
//   req, req_addr, req_ready  - request handshake from the core (accepted in IDLE)
//   core_wdata, core_mvalid   - core bus drive, forwarded while connected
//   core_done                 - core ends the data phase
//   ack                       - address decoder acknowledge
//   mwdata, mvalid            - bus serial data and valid
//   grant                     - core owns the bus
//   err                       - one-cycle pulse on ack timeout
module master_addr_tx
  import master_addr_tx_pkg::*;
#(
  parameter int DEVICE_ADDR_WIDTH = DEFAULT_DEVICE_ADDR_WIDTH,
  parameter int ACK_TIMEOUT       = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         req,
  input  logic [DEVICE_ADDR_WIDTH-1:0] req_addr,
  output logic                         req_ready,
  input  logic                         core_wdata,
  input  logic                         core_mvalid,
  input  logic                         core_done,
  input  logic                         ack,
  output logic                         mwdata,
  output logic                         mvalid,
  output logic                         grant,
  output logic                         err
);

  localparam int BIT_W = (DEVICE_ADDR_WIDTH > 1) ? $clog2(DEVICE_ADDR_WIDTH) : 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DEVICE_ADDR_WIDTH - 1);
  localparam logic [TO_W-1:0]  LAST_WAIT = TO_W'(ACK_TIMEOUT - 1);

  bus_state_e       state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             err_q;
  logic             load, shift, timeout, addr_bit;

  addr_piso #(.W(DEVICE_ADDR_WIDTH)) u_piso (
    .clk   (clk),
    .rstn  (rstn),
    .load  (load),
    .shift (shift),
    .din   (req_addr),
    .dout  (addr_bit)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          load    = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        shift = 1'b1;
        if (bit_cnt_q == LAST_BIT) state_d = ACK_WAIT;
      end
      ACK_WAIT: begin
        // ack is checked first so it wins over the final timeout cycle
        if (ack) begin
          state_d = CONNECTED;
        end else if (to_cnt_q == LAST_WAIT) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      CONNECTED: begin
        if (core_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters only advance while the state is held, so every entry starts at 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= (state_q == ADDR && state_d == ADDR) ? bit_cnt_q + BIT_W'(1) : '0;
      to_cnt_q  <= (state_q == ACK_WAIT && state_d == ACK_WAIT) ? to_cnt_q + TO_W'(1) : '0;
      err_q     <= timeout;
    end
  end

  always_comb begin
    mvalid = 1'b0;
    mwdata = 1'b0;
    case (state_q)
      ADDR: begin
        mvalid = 1'b1;
        mwdata = addr_bit;
      end
      CONNECTED: begin
        mvalid = core_mvalid;
        mwdata = core_wdata;
      end
      default: ;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign grant     = (state_q == CONNECTED);
  assign err       = err_q;

endmodule

// File: tb/tb_master_addr_tx.sv
// tb/tb_master_addr_tx.sv - directed self-checking bench for master_addr_tx
module tb_master_addr_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req = 1'b0;
  logic [3:0] req_addr = 4'd0;
  logic       req_ready;
  logic       core_wdata = 1'b0;
  logic       core_mvalid = 1'b0;
  logic       core_done = 1'b0;
  logic       ack = 1'b0;
  logic       mwdata, mvalid, grant, err;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  master_addr_tx #(.DEVICE_ADDR_WIDTH(4), .ACK_TIMEOUT(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .core_wdata  (core_wdata),
    .core_mvalid (core_mvalid),
    .core_done   (core_done),
    .ack         (ack),
    .mwdata      (mwdata),
    .mvalid      (mvalid),
    .grant       (grant),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_bits;
    logic [3:0] got;

    // reset state
    step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mvalid", mvalid, 0);
    chk("rst_mwdata", mwdata, 0);
    chk("rst_grant", grant, 0);
    chk("rst_err", err, 0);
    rstn = 1'b1;
    step();

    // address 0110, ack in cycle 5, grant from cycle 6
    req = 1'b1; req_addr = 4'b0110;
    step();
    req = 1'b0;
    chk("t1_req_ready_addr", req_ready, 0);
    exp_bits = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_mvalid_b%0d", k), mvalid, 1);
      chk($sformatf("t1_mwdata_b%0d", k), mwdata, exp_bits[k]);
      step();
    end
    chk("t1_mvalid_ackwait", mvalid, 0);
    chk("t1_grant_ackwait", grant, 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t1_grant", grant, 1);
    chk("t1_req_ready_conn", req_ready, 0);

    // pass-through of core bits while connected
    for (int i = 0; i < 4; i++) begin
      core_wdata  = i[0];
      core_mvalid = i[1];
      #1;
      chk($sformatf("pt_mvalid_%0d", i), mvalid, i[1]);
      chk($sformatf("pt_mwdata_%0d", i), mwdata, i[0]);
      step();
    end
    core_wdata = 1'b0; core_mvalid = 1'b0;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("done_req_ready", req_ready, 1);
    chk("done_grant", grant, 0);

    // back-to-back request of invalid address 0011, with ignored req pulses
    req = 1'b1; req_addr = 4'b0011;
    step();
    chk("b2b_mvalid", mvalid, 1);
    chk("b2b_mwdata_b0", mwdata, 1);
    req_addr = 4'b1100;                 // req still high during ADDR
    step();
    req = 1'b0;
    chk("ign_mwdata_b1", mwdata, 1);
    step();
    chk("ign_mwdata_b2", mwdata, 0);
    step();
    chk("ign_mwdata_b3", mwdata, 0);
    step();
    chk("to_mvalid", mvalid, 0);        // cycle 5, first ACK_WAIT cycle
    req = 1'b1;
    step();
    req = 1'b0;
    chk("to_req_ignored", req_ready, 0);
    for (int c = 6; c <= 12; c++) begin
      chk($sformatf("to_err_low_c%0d", c), err, 0);
      chk($sformatf("to_grant_low_c%0d", c), grant, 0);
      step();
    end
    chk("to_err_pulse", err, 1);
    chk("to_req_ready", req_ready, 1);
    chk("to_grant", grant, 0);
    step();
    chk("to_err_single", err, 0);

    // ack exactly in the final timeout cycle wins
    req = 1'b1; req_addr = 4'b1001;
    step();
    req = 1'b0;
    for (int c = 1; c < 12; c++) step();
    chk("edge_still_waiting", req_ready, 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("edge_grant", grant, 1);
    chk("edge_err", err, 0);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("edge_idle", req_ready, 1);

    // asynchronous reset in the middle of the address phase
    req = 1'b1; req_addr = 4'b1111;
    step();
    req = 1'b0;
    step();
    chk("arst_mvalid_before", mvalid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_mvalid_async", mvalid, 0);
    chk("arst_req_ready_async", req_ready, 1);
    step();
    rstn = 1'b1;
    step();
    chk("arst_idle_ready", req_ready, 1);
    chk("arst_idle_mvalid", mvalid, 0);

    // loopback with a decoder that accepts addresses 0..2
    for (int a = 0; a < 4; a++) begin
      req = 1'b1; req_addr = a[3:0];
      step();
      req = 1'b0;
      got = 4'd0;
      for (int k = 0; k < 4; k++) begin
        if (mvalid) got[k] = mwdata;
        step();
      end
      chk($sformatf("lb_addr_%0d", a), got, a);
      ack = (got < 4'd3);
      step();
      ack = 1'b0;
      if (a < 3) begin
        chk($sformatf("lb_grant_%0d", a), grant, 1);
        core_mvalid = 1'b1; core_wdata = 1'b1; core_done = 1'b1;
        #1 chk($sformatf("lb_data_%0d", a), mwdata, 1);
        step();
        core_mvalid = 1'b0; core_wdata = 1'b0; core_done = 1'b0;
        chk($sformatf("lb_idle_%0d", a), req_ready, 1);
      end else begin
        for (int c = 0; c < 7; c++) step();
        chk("lb_err_3", err, 1);
        chk("lb_idle_3", req_ready, 1);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
